// File: rtl/demux_1x16_regbank_pkg.sv
// Shared constants, state encoding and one-hot decode helper for the 1:16
// write demultiplexer register bank.
package demux_1x16_regbank_pkg;

  localparam int WIDTH = 64;
  localparam int SEL_W = 4;
  localparam int NREG  = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic [NREG-1:0] onehot_dec(input logic [SEL_W-1:0] sel);
    logic [NREG-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1x16_regbank_decoder_4x16.sv
// Combinational 4-to-16 one-hot decoder with enable; all-zero when disabled.
module decoder_4x16
  import demux_1x16_regbank_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  assign onehot = en ? onehot_dec(sel) : '0;

endmodule

// File: rtl/demux_1x16_regbank.sv
// 1:16 write demultiplexer into a bank of 16 registers, with a one-request
// pending stage and a sequenced 16-cycle bank-clear sweep.
module demux_1x16_regbank #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      clear,
  output logic                      clear_done,
  output logic [(1<<SEL_W)-1:0]     wr_onehot,
  output logic [(WIDTH<<SEL_W)-1:0] q_flat
);
  import demux_1x16_regbank_pkg::*;

  localparam int NR = 1 << SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             clear_done_q, clear_done_d;
  logic [NR-1:0]    wr_onehot_q, wr_onehot_d;
  logic             pend_valid_q, pend_valid_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] regs_q [NR];
  logic [WIDTH-1:0] regs_d [NR];
  logic [NR-1:0]    commit_oh, sweep_oh;
  logic             accept, sweeping;

  // A clear request blocks acceptance in the same cycle it is raised.
  assign wr_ready = (state_q == ST_RUN) && !clear;
  assign accept   = wr_valid && wr_ready;
  assign sweeping = (state_q == ST_CLEAR);

  decoder_4x16 u_commit_dec (
    .en     (pend_valid_q),
    .sel    (pend_sel_q),
    .onehot (commit_oh)
  );

  decoder_4x16 u_sweep_dec (
    .en     (sweeping),
    .sel    (idx_q),
    .onehot (sweep_oh)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clear_done_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (clear) begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    end else begin
      idx_d = idx_q + SEL_W'(1);
      if (idx_q == SEL_W'(NR - 1)) begin
        state_d      = ST_RUN;
        clear_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    pend_valid_d = accept;
    pend_sel_d   = accept ? wr_sel  : pend_sel_q;
    pend_data_d  = accept ? wr_data : pend_data_q;
    wr_onehot_d  = commit_oh | sweep_oh;
    for (int k = 0; k < NR; k++) begin
      regs_d[k] = regs_q[k];
      if (commit_oh[k]) regs_d[k] = pend_data_q;
      if (sweep_oh[k])  regs_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      clear_done_q <= 1'b0;
      wr_onehot_q  <= '0;
      pend_valid_q <= 1'b0;
      for (int k = 0; k < NR; k++) regs_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clear_done_q <= clear_done_d;
      wr_onehot_q  <= wr_onehot_d;
      pend_valid_q <= pend_valid_d;
      for (int k = 0; k < NR; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Pending payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_sel_q  <= pend_sel_d;
    pend_data_q <= pend_data_d;
  end

  assign clear_done = clear_done_q;
  assign wr_onehot  = wr_onehot_q;

  for (genvar g = 0; g < NR; g++) begin : g_flat
    assign q_flat[WIDTH*g +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_demux_1x16_regbank.sv
// Directed and randomized bench for demux_1x16_regbank against a
// transaction-level model of the register bank and clear sweep.
module tb_demux_1x16_regbank;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_sel;
  logic [63:0]   wr_data;
  logic          clear;
  logic          clear_done;
  logic [15:0]   wr_onehot;
  logic [1023:0] q_flat;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;

  // Reference model: register array, one pending write, sweep cycles left.
  logic [63:0] m_reg [16];
  bit          m_pv;
  logic [3:0]  m_ps;
  logic [63:0] m_pd;
  int          m_left;
  logic [15:0] e_oh;
  bit          e_done;

  demux_1x16_regbank dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .clear      (clear),
    .clear_done (clear_done),
    .wr_onehot  (wr_onehot),
    .q_flat     (q_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_reg[k] = '0;
    m_pv   = 1'b0;
    m_ps   = '0;
    m_pd   = '0;
    m_left = 0;
    e_oh   = '0;
    e_done = 1'b0;
  endtask

  task automatic chk_outputs(input string pfx);
    chk({pfx, "_onehot"}, 64'(wr_onehot), 64'(e_oh));
    chk({pfx, "_done"}, 64'(clear_done), 64'(e_done));
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_reg%0d", pfx, k), q_flat[64*k +: 64], m_reg[k]);
  endtask

  // Called at a falling edge: drive, check ready, advance model over one
  // rising edge, then check registered outputs at the next falling edge.
  task automatic cycle(input bit v, input logic [3:0] s, input logic [63:0] d, input bit c);
    bit exp_rdy;
    bit acc;
    int pos;
    wr_valid = v;
    wr_sel   = s;
    wr_data  = d;
    clear    = c;
    #1;
    exp_rdy = (m_left == 0) && !c;
    chk("wr_ready", 64'(wr_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    e_oh   = '0;
    e_done = 1'b0;
    if (m_pv) begin
      m_reg[m_ps] = m_pd;
      e_oh[m_ps]  = 1'b1;
    end
    if (m_left > 0) begin
      pos        = 16 - m_left;
      m_reg[pos] = '0;
      e_oh[pos]  = 1'b1;
      m_left--;
      e_done     = (m_left == 0);
    end else if (c) begin
      m_left = 16;
    end
    m_pv = acc;
    if (acc) begin
      m_ps = s;
      m_pd = d;
    end
    @(negedge clk);
    if (clear_done) done_count++;
    chk_outputs("cyc");
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    clear    = 1'b0;
    model_reset();

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk_outputs("rst");
    end
    reset_n = 1'b1;
    cycle(1'b0, 4'd0, 64'd0, 1'b0);

    // Single write with two-edge latency
    cycle(1'b1, 4'd5, 64'hDEAD_BEEF_0123_4567, 1'b0);
    chk("single_no_bypass", q_flat[5*64 +: 64], 64'd0);
    cycle(1'b0, 4'd0, 64'd0, 1'b0);
    chk("single_oh", 64'(wr_onehot), 64'h0020);
    chk("single_reg5", q_flat[5*64 +: 64], 64'hDEAD_BEEF_0123_4567);

    // Streaming writes to every register
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'(k), 64'(k) * 64'h1111, 1'b0);
    cycle(1'b0, 4'd0, 64'd0, 1'b0);
    chk("stream_oh_last", 64'(wr_onehot), 64'h8000);
    for (int k = 0; k < 16; k++)
      chk($sformatf("stream_reg%0d", k), q_flat[64*k +: 64], 64'(k) * 64'h1111);

    // Write then clear, with wr_valid held during the sweep
    cycle(1'b1, 4'd3, 64'd7, 1'b0);
    cycle(1'b0, 4'd0, 64'd0, 1'b1);
    chk("wc_reg3", q_flat[3*64 +: 64], 64'd7);
    done_count = 0;
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'($urandom), {$urandom(), $urandom()}, 1'b0);
    chk("wc_done_count", 64'(done_count), 64'd1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("wc_zero%0d", k), q_flat[64*k +: 64], 64'd0);
    cycle(1'b1, 4'd9, 64'h0ABC, 1'b0);
    cycle(1'b0, 4'd0, 64'd0, 1'b0);
    chk("post_clear_reg9", q_flat[9*64 +: 64], 64'h0ABC);

    // Async reset in the middle of a sweep
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'(k), 64'(k) * 64'h1111 + 64'd1, 1'b0);
    cycle(1'b0, 4'd0, 64'd0, 1'b0);
    cycle(1'b0, 4'd0, 64'd0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 4'd0, 64'd0, 1'b0);
    chk("mid_reg8", q_flat[8*64 +: 64], 64'h8889);
    chk("mid_reg15", q_flat[15*64 +: 64], 64'hFFFF + 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("async");
    @(negedge clk);
    reset_n    = 1'b1;
    done_count = 0;
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'd0, 64'd0, 1'b0);
    chk("async_no_done", 64'(done_count), 64'd0);

    // Held clear repeats the sweep
    for (int k = 0; k < 40; k++) cycle(1'b1, 4'($urandom), {$urandom(), $urandom()}, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 9) < 7, 4'($urandom), {$urandom(), $urandom()},
            $urandom_range(0, 29) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
